// File: rtl/car_sensor_fsm.sv
// Gate beam decoder for the parking-lot counter.
// Two beam sensors (A = outer, B = inner) are synchronised and debounced.
// Their order is tracked to produce one-cycle Car_in / Car_out pulses,
// and a saturating occupancy count drives the Full/Empty flags.
// Optional build macro: CAR_TIMEOUT_EN adds a stall timer. When a partial
// sequence sits unchanged for TIMEOUT_CYC cycles, the FSM goes to ERR.
module car_sensor_fsm #(
  parameter int CAPACITY    = 3,
  parameter int CW          = 2,
  parameter int DEB_CYC     = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          Sens_a,
  input  logic          Sens_b,
  output logic          Car_in,
  output logic          Car_out,
  output logic [CW-1:0] count,
  output logic          Full,
  output logic          Empty,
  output logic          Err
);

  localparam int            DW    = $clog2(DEB_CYC + 1);
  localparam logic [DW-1:0] DEB_V = DW'(DEB_CYC);
  localparam logic [CW-1:0] CAP_V = CW'(CAPACITY);

  typedef enum logic [2:0] {IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3, ERR} state_t;

  // Bit 1 carries sensor A and bit 0 carries sensor B, so ab = {a, b}.
  logic [1:0]    sync1_q, sync2_q, filt_q;
  logic [DW-1:0] deb_q [2];
  logic [1:0]    ab;
  state_t        state_q, state_d;
  logic          car_in_q, car_in_d, car_out_q, car_out_d;
  logic [CW-1:0] count_q;

  // Two-flop synchroniser for the asynchronous beam inputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {Sens_a, Sens_b};
      sync2_q <= sync1_q;
    end
  end

  // Per-bit debounce: a filtered bit follows its synced bit only after
  // the two have disagreed for DEB_CYC consecutive cycles.
  always_ff @(posedge CLK) begin
    if (RST) begin
      filt_q   <= '0;
      deb_q[0] <= '0;
      deb_q[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          deb_q[i] <= '0;
        end else if (deb_q[i] + 1'b1 == DEB_V) begin
          filt_q[i] <= sync2_q[i];
          deb_q[i]  <= '0;
        end else begin
          deb_q[i] <= deb_q[i] + 1'b1;
        end
      end
    end
  end

  assign ab = filt_q;

`ifdef CAR_TIMEOUT_EN
  localparam int            TW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_V = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] tmr_q, tmr_d;
  logic          stall;

  // Stall timer: counts while the FSM waits in a partial state.
  always_ff @(posedge CLK) begin
    if (RST) tmr_q <= '0;
    else     tmr_q <= tmr_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYC;
`endif

  // Beam-order tracking. Each state implies one ab code. A one-bit change
  // steps forward or back along a path. A two-bit change is illegal.
  always_comb begin
    state_d   = state_q;
    car_in_d  = 1'b0;
    car_out_d = 1'b0;
    case (state_q)
      IDLE: case (ab)
              2'b10:   state_d = IN1;
              2'b01:   state_d = OUT1;
              2'b11:   state_d = ERR;
              default: state_d = IDLE;
            endcase
      IN1:  case (ab)
              2'b11:   state_d = IN2;
              2'b00:   state_d = IDLE;
              2'b01:   state_d = ERR;
              default: state_d = IN1;
            endcase
      IN2:  case (ab)
              2'b01:   state_d = IN3;
              2'b10:   state_d = IN1;
              2'b00:   state_d = ERR;
              default: state_d = IN2;
            endcase
      IN3:  case (ab)
              2'b00:   begin state_d = IDLE; car_in_d = 1'b1; end
              2'b11:   state_d = IN2;
              2'b10:   state_d = ERR;
              default: state_d = IN3;
            endcase
      OUT1: case (ab)
              2'b11:   state_d = OUT2;
              2'b00:   state_d = IDLE;
              2'b10:   state_d = ERR;
              default: state_d = OUT1;
            endcase
      OUT2: case (ab)
              2'b10:   state_d = OUT3;
              2'b01:   state_d = OUT1;
              2'b00:   state_d = ERR;
              default: state_d = OUT2;
            endcase
      OUT3: case (ab)
              2'b00:   begin state_d = IDLE; car_out_d = 1'b1; end
              2'b11:   state_d = OUT2;
              2'b01:   state_d = ERR;
              default: state_d = OUT3;
            endcase
      ERR:  if (ab == 2'b00) state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef CAR_TIMEOUT_EN
    stall = (state_q != IDLE) && (state_q != ERR) && (state_d == state_q);
    tmr_d = stall ? tmr_q + 1'b1 : '0;
    if (stall && (tmr_q == TMO_V)) state_d = ERR;
`endif
  end

  // State, registered pulses and the saturating occupancy count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      car_in_q  <= 1'b0;
      car_out_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      car_in_q  <= car_in_d;
      car_out_q <= car_out_d;
      if (car_in_d && (count_q != CAP_V))
        count_q <= count_q + 1'b1;
      else if (car_out_d && (count_q != '0))
        count_q <= count_q - 1'b1;
    end
  end

  assign Car_in  = car_in_q;
  assign Car_out = car_out_q;
  assign count   = count_q;
  assign Full    = (count_q == CAP_V);
  assign Empty   = (count_q == '0);
  assign Err     = (state_q == ERR);

endmodule

// File: tb/tb_car_sensor_fsm.sv
// Directed bench for car_sensor_fsm. Expected pulses are queued when the
// closing 00 of a full sequence is driven. They are popped and compared
// whenever the DUT emits a pulse.
module tb_car_sensor_fsm;

  localparam int CAP = 3;
  localparam int TMO = 1000;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       Sens_a = 1'b0;
  logic       Sens_b = 1'b0;
  logic       Car_in, Car_out, Full, Empty, Err;
  logic [1:0] count;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [1:0] exp_q [$];

  car_sensor_fsm #(.CAPACITY(CAP), .CW(2), .DEB_CYC(4), .TIMEOUT_CYC(TMO)) dut (
    .CLK(CLK), .RST(RST), .Sens_a(Sens_a), .Sens_b(Sens_b),
    .Car_in(Car_in), .Car_out(Car_out), .count(count),
    .Full(Full), .Empty(Empty), .Err(Err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; any pulse seen is matched against the scoreboard.
  task automatic cycle();
    logic [1:0] e;
    @(negedge CLK);
    if (Car_in || Car_out) begin
      n_cmp++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL unexpected_pulse observed in/out=%b%b expected=none", Car_in, Car_out);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pulse_kind", {30'd0, Car_in, Car_out}, {30'd0, e});
      end
    end
  endtask

  task automatic step(input logic [1:0] ab, input int n);
    Sens_a = ab[1];
    Sens_b = ab[0];
    repeat (n) cycle();
  endtask

  task automatic entry();
    step(2'b10, 10); step(2'b11, 10); step(2'b01, 10);
    exp_q.push_back(2'b10);
    step(2'b00, 10);
    chk("entry_pulse_seen", exp_q.size(), 0);
  endtask

  task automatic exit_seq();
    step(2'b01, 10); step(2'b11, 10); step(2'b10, 10);
    exp_q.push_back(2'b01);
    step(2'b00, 10);
    chk("exit_pulse_seen", exp_q.size(), 0);
  endtask

  initial begin
    // Reset
    repeat (3) cycle();
    RST = 1'b0;
    cycle();
    chk("rst_car_in", Car_in, 0);
    chk("rst_car_out", Car_out, 0);
    chk("rst_count", count, 0);
    chk("rst_full", Full, 0);
    chk("rst_empty", Empty, 1);
    chk("rst_err", Err, 0);
    step(2'b00, 5);

    // Exit with the lot empty: pulse still emitted, count holds at 0
    exit_seq();
    chk("underflow_count", count, 0);
    chk("underflow_empty", Empty, 1);

    // Full entry
    entry();
    chk("t1_count", count, 1);
    chk("t1_empty", Empty, 0);

    // Full exit
    exit_seq();
    chk("t2_count", count, 0);
    chk("t2_empty", Empty, 1);

    // Entry then reversal: no pulse
    step(2'b10, 10); step(2'b11, 10); step(2'b10, 10); step(2'b00, 10);
    chk("t3_count", count, 0);
    chk("t3_err", Err, 0);

    // Short glitches on each sensor are filtered out
    step(2'b10, 3); step(2'b00, 10);
    step(2'b01, 3); step(2'b00, 10);
    chk("t4_count", count, 0);
    chk("t4_err", Err, 0);
    entry();
    chk("t4_entry_after_glitch", count, 1);
    exit_seq();
    chk("t4_exit_after_glitch", count, 0);

    // Saturation
    entry(); chk("t5_count1", count, 1);
    entry(); chk("t5_count2", count, 2);
    chk("t5_full_before", Full, 0);
    entry(); chk("t5_count3", count, 3);
    chk("t5_full", Full, 1);
    entry(); chk("t5_count_sat", count, 3);
    chk("t5_full_sat", Full, 1);
    exit_seq();
    chk("t5_count_exit", count, 2);
    chk("t5_full_clear", Full, 0);

    // Both bits change at once: ERR until ab returns to 00
    step(2'b11, 10);
    chk("t6_err_set", Err, 1);
    step(2'b01, 10);
    chk("t6_err_hold", Err, 1);
    step(2'b00, 10);
    chk("t6_err_clear", Err, 0);
    chk("t6_count", count, 2);
    entry();
    chk("t6_entry_after_err", count, 3);

    // Reset mid-sequence with both beams still blocked
    step(2'b10, 10); step(2'b11, 10);
    RST = 1'b1;
    repeat (2) cycle();
    RST = 1'b0;
    cycle();
    chk("midrst_count", count, 0);
    chk("midrst_empty", Empty, 1);
    chk("midrst_err", Err, 0);
    step(2'b11, 10);
    chk("midrst_err_after", Err, 1);
    step(2'b00, 10);
    chk("midrst_err_clear", Err, 0);
    chk("midrst_count_after", count, 0);

`ifdef CAR_TIMEOUT_EN
    // A partial sequence that stalls times out into ERR
    step(2'b10, TMO + 20);
    chk("tmo_err", Err, 1);
    step(2'b00, 10);
    chk("tmo_err_clear", Err, 0);
    chk("tmo_count", count, 0);
`endif

    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
